cache_fill_fsm: RTL
===================

Name: cache_fill_fsm

Overview:
- Miss-handling controller between the CPU's cache arrays and a multi-cycle main memory.
- On a cache miss it fetches the whole 16-byte block (8 words) from memory.
- It drives data-array writes for each returned word and a tag-array write on the last word.
- It holds `fsm_busy` high so the CPU stalls until the fill is complete.

Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache block (block = 16 bytes, byte-addressed).
- MEM_LATENCY, 4, cycles from `memory_enable` to matching `memory_data_valid`. Informational only; the FSM counts `memory_data_valid` pulses, not cycles.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- miss_detected  input  1  cache lookup missed this cycle
- miss_address  input  16  byte address that missed
- memory_data_valid  input  1  memory returns one word this cycle (in issue order)
- fsm_busy  output  1  fill in progress; CPU must stall
- memory_enable  output  1  issue a read request to memory this cycle
- memory_address  output  16  byte address of the issued read
- write_data_array  output  1  write the returned word into the data array this cycle
- fill_word_addr  output  16  byte address of the word being written to the data array
- write_tag_array  output  1  write tag and valid bit for the block this cycle

Behaviour:
- One clock; reset is synchronous and active-low on rst_n. rst_n low at a rising edge forces:
  - state IDLE
  - issue_cnt = 0, recv_cnt = 0, block_base = 0x0000
- While rst_n is low, all outputs are 0, including `fsm_busy` regardless of `miss_detected`.
- States: IDLE, FILL.
- IDLE:
  - memory_enable = write_data_array = write_tag_array = 0.
  - fsm_busy = miss_detected (combinational, so the CPU stalls in the miss cycle).
  - If miss_detected: latch block_base = {miss_address[15:4], 4'h0}, clear both counters, next state FILL.
  - memory_data_valid in IDLE is ignored: no array write.
- FILL:
  - fsm_busy = 1.
  - miss_detected is ignored.
  - Issue side:
    - If issue_cnt < 8: memory_enable = 1, memory_address = block_base + 2*issue_cnt, issue_cnt++.
    - Otherwise memory_enable = 0.
    - One request per cycle, back-to-back; memory is pipelined.
  - Receive side:
    - If memory_data_valid and recv_cnt < 8: write_data_array = 1, fill_word_addr = block_base + 2*recv_cnt, recv_cnt++.
  - Completion:
    - When memory_data_valid and recv_cnt == 7, write_tag_array = 1 in the same cycle as the last data write; next state IDLE.
    - The next cycle (IDLE) may accept a new miss immediately.
  - Issue and receive may occur in the same cycle and are independent.
- Address arithmetic is 16-bit. block_base is 16-byte aligned, so the word offset (bits 3:1) never carries into bit 4; no wrap outside the block.
- When idle (not writing), memory_address and fill_word_addr hold block_base.
- Counters are 4 bits wide (0..8). Stray valids after recv_cnt reaches 8 cannot occur in FILL, because the FSM leaves FILL on the 8th valid.
- Reset mid-fill: the fill is abandoned, no tag write occurs, IDLE on the next cycle. Late memory_data_valid pulses arriving in IDLE are ignored.
- Timing with MEM_LATENCY = 4, miss in cycle 0:

| Cycles | Event |
|---|---|
| 1..8 | memory_enable high |
| 5..12 | data valid, data-array writes |
| 12 | tag write |
| 0..12 | fsm_busy high (13 cycles) |
| 13 | fsm_busy low, unless a new miss |

Test Plan:
- Reset, then miss_detected=1 with miss_address=0x1236 in cycle 0, 4-cycle memory model:
  - memory_address = 0x1230, 0x1232, ... 0x123E in cycles 1..8.
  - write_data_array in cycles 5..12 with fill_word_addr 0x1230..0x123E.
  - write_tag_array only in cycle 12; fsm_busy high cycles 0..12 and low in cycle 13.
- Miss at 0xFFFE:
  - block_base = 0xFFF0; addresses 0xFFF0..0xFFFE, no wrap to 0x0000.
  - Exactly 8 data writes and 1 tag write.
- Irregular memory_data_valid (gaps of 0-3 cycles between pulses):
  - Still exactly 8 data writes with ascending addresses.
  - Tag write coincides with the 8th valid; busy stays high until then.
- miss_detected held high through an entire fill of 0x0040, with miss_address changed to 0x0080 mid-fill:
  - The 0x0040 block completes unchanged.
  - A new fill of 0x0080 starts in the cycle after the tag write (memory_address = 0x0080 one cycle later).
- rst_n driven low in cycle 7 of a fill:
  - Next cycle all outputs are 0, state IDLE, no tag write.
  - Subsequent valid pulses produce no writes.
  - A new miss after reset fills normally.
- memory_data_valid pulsed while IDLE with miss_detected=0 -> write_data_array, write_tag_array and fsm_busy all stay 0.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches one 8-word block from pipelined memory,
// writes each returned word into the data array and the tag on the last word.
module cache_fill_fsm #(
   parameter int WORDS_PER_BLOCK = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        miss_detected,
   input  logic [15:0] miss_address,
   input  logic        memory_data_valid,
   output logic        fsm_busy,
   output logic        memory_enable,
   output logic [15:0] memory_address,
   output logic        write_data_array,
   output logic [15:0] fill_word_addr,
   output logic        write_tag_array,
   output logic        dbg_state
);

   // Memory handshake: memory_enable is a one-cycle request with no ready;
   // memory_data_valid returns exactly one word per accepted request, in issue order.
   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   localparam logic [3:0] NUM_WORDS = 4'(WORDS_PER_BLOCK);
   localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_BLOCK - 1);

   state_t      state_q, state_d;
   logic [3:0]  issue_cnt_q, issue_cnt_d;
   logic [3:0]  recv_cnt_q, recv_cnt_d;
   logic [15:0] block_base_q, block_base_d;

   logic        busy_c, mem_en_c, wr_data_c, wr_tag_c;
   logic [15:0] mem_addr_c, fill_addr_c;

   always_comb begin
      state_d      = state_q;
      issue_cnt_d  = issue_cnt_q;
      recv_cnt_d   = recv_cnt_q;
      block_base_d = block_base_q;
      busy_c       = 1'b0;
      mem_en_c     = 1'b0;
      wr_data_c    = 1'b0;
      wr_tag_c     = 1'b0;
      mem_addr_c   = block_base_q;
      fill_addr_c  = block_base_q;

      case (state_q)
         IDLE: begin
            busy_c = miss_detected;
            if (miss_detected) begin
               block_base_d = {miss_address[15:4], 4'h0};
               issue_cnt_d  = 4'd0;
               recv_cnt_d   = 4'd0;
               state_d      = FILL;
            end
         end
         FILL: begin
            busy_c = 1'b1;
            if (issue_cnt_q < NUM_WORDS) begin
               mem_en_c    = 1'b1;
               mem_addr_c  = block_base_q + {11'd0, issue_cnt_q, 1'b0};
               issue_cnt_d = issue_cnt_q + 4'd1;
            end
            if (memory_data_valid && (recv_cnt_q < NUM_WORDS)) begin
               wr_data_c   = 1'b1;
               fill_addr_c = block_base_q + {11'd0, recv_cnt_q, 1'b0};
               recv_cnt_d  = recv_cnt_q + 4'd1;
               // Tag goes with the final word so the line only becomes valid once complete.
               if (recv_cnt_q == LAST_WORD) begin
                  wr_tag_c = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         issue_cnt_q  <= 4'd0;
         recv_cnt_q   <= 4'd0;
         block_base_q <= 16'h0000;
      end else begin
         state_q      <= state_d;
         issue_cnt_q  <= issue_cnt_d;
         recv_cnt_q   <= recv_cnt_d;
         block_base_q <= block_base_d;
      end
   end

   // Outputs are forced low while reset is asserted, even mid-fill.
   assign fsm_busy         = rst_n & busy_c;
   assign memory_enable    = rst_n & mem_en_c;
   assign write_data_array = rst_n & wr_data_c;
   assign write_tag_array  = rst_n & wr_tag_c;
   assign memory_address   = rst_n ? mem_addr_c  : 16'h0000;
   assign fill_word_addr   = rst_n ? fill_addr_c : 16'h0000;
   assign dbg_state        = rst_n & (state_q == FILL);

endmodule
